// File: rtl/serial_adder_n.sv
// Bit-serial ripple adder: one full-add step per clock, LSB first, start/busy/done handshake.
// Optional subtract mode and signed-overflow flag are enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_SUB_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit, c_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    s_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    c_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    res_shift = res_sr_q >> 1;
    res_shift[WIDTH-1] = s_bit;

    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b == a + ~b + 1; cout then reads as "no borrow"
          if (sub) begin
            b_sr_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          res_sr_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        carry_d  = c_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this final step
          sum_d   = res_shift;
          cout_d  = c_nxt;
          ovf_d   = carry_q ^ c_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: WIDTH=8 and WIDTH=1 instances, arithmetic reference model.
module tb_serial_adder_n;
  localparam int W = 8;

  typedef struct {
    int sum;
    bit cout;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [W-1:0] a8, b8, sum8;
  logic         start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0]   a1, b1, sum1;

  serial_adder_n #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8), .ovf(ovf8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_n #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1), .ovf(ovf1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

`ifndef SERIAL_ADDER_SUB_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  exp_t q8[$];
  exp_t q1[$];
  int last_sum8 = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int w, input int a, input int b, input bit c, input bit s);
    exp_t e;
    int mask, sa, sb, r, t;
    mask = (1 << w) - 1;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    if (s) begin
      t = a - b;
      e.cout = (a >= b);
      r = sa - sb;
    end else begin
      t = a + b + int'(c);
      e.cout = (t > mask);
      r = sa + sb + int'(c);
    end
    e.sum = t & mask;
    e.ovf = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("dut8 unexpected done", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8 sum", int'(sum8), e.sum);
        chk("dut8 cout", int'(cout8), int'(e.cout));
`ifdef SERIAL_ADDER_SUB_EN
        chk("dut8 ovf", int'(ovf8), int'(e.ovf));
`endif
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 sum", int'(sum1), e.sum);
        chk("dut1 cout", int'(cout1), int'(e.cout));
`ifdef SERIAL_ADDER_SUB_EN
        chk("dut1 ovf", int'(ovf1), int'(e.ovf));
`endif
      end
    end
  end

  // One WIDTH=8 operation with timing checks; junk pulses start while busy (cycle 3) and in DONE.
  task automatic run8(input int a, input int b, input bit c, input bit s, input bit junk);
    exp_t e;
    e = model(W, a, b, c, s);
    @(negedge clk);
    a8 = W'(a); b8 = W'(b); cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = W'($urandom); b8 = W'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    for (int i = 1; i <= W; i++) begin
      chk("busy during run", int'(busy8), 1);
      chk("no done during run", int'(done8), 0);
      chk("sum held during run", int'(sum8), last_sum8);
      if (junk && i == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else start8 = 1'b0;
      @(negedge clk);
    end
    chk("done at start+W+1", int'(done8), 1);
    chk("busy low in done", int'(busy8), 0);
    last_sum8 = e.sum;
    if (junk) begin
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      chk("single done pulse", int'(done8), 0);
      chk("start in done ignored", int'(busy8), 0);
    end
  endtask

  task automatic run1(input int a, input int b, input bit c, input bit s);
    @(negedge clk);
    a1 = 1'(a); b1 = 1'(b); cin1 = c; sub1 = s; start1 = 1'b1;
    q1.push_back(model(1, a, b, c, s));
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1 busy one cycle", int'(busy1), 1);
    @(negedge clk);
    chk("dut1 done at start+2", int'(done1), 1);
  endtask

  initial begin
    bit sb;
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy8), 0);
    chk("reset done", int'(done8), 0);
    chk("reset sum", int'(sum8), 0);
    chk("reset cout", int'(cout8), 0);
    chk("reset ovf", int'(ovf8), 0);
    rst = 1'b0;

    run8(8'h5A, 8'h3C, 0, 0, 0);
    run8(8'hFF, 8'h01, 0, 0, 0);
    run8(8'h00, 8'h00, 1, 0, 0);
    run8(8'h12, 8'h34, 0, 0, 1);

    // Reset in RUN cycle 4 discards the operation
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-run reset busy", int'(busy8), 0);
    chk("mid-run reset done", int'(done8), 0);
    chk("mid-run reset sum", int'(sum8), 0);
    chk("mid-run reset cout", int'(cout8), 0);
    last_sum8 = 0;
    repeat (W + 3) @(negedge clk);
    chk("idle after reset", int'(busy8), 0);
    run8(8'hAA, 8'h55, 1, 0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h10, 8'h01, 0, 1, 0);
    run8(8'h01, 8'h02, 1, 1, 0);
    run8(8'h80, 8'h01, 0, 1, 0);
    run8(8'h7F, 8'h01, 0, 0, 0);
`endif

    for (int n = 0; n < 24; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run8(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom), sb, (n % 5) == 0);
    end

    run1(1, 1, 1, 0);
    for (int n = 0; n < 8; n++) run1(n & 1, (n >> 1) & 1, 1'((n >> 2) & 1), 0);
`ifdef SERIAL_ADDER_SUB_EN
    run1(0, 1, 0, 1);
    run1(1, 0, 0, 1);
`endif

    repeat (4) @(negedge clk);
    chk("dut8 scoreboard drained", q8.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
